// File: rtl/hart_mem_arbiter_if.sv
// rtl/hart_mem_arbiter_if.sv - HART-side and memory-side signal bundle for the IC/DM memory arbiter.
// The i_DM_atomic signal exists only when ARB_ATOMIC_LOCK_EN is defined.
interface hart_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_IC_DataReq;
  logic [XLEN-1:0] i_IC_Addr;
  logic            o_IC_MemReady;
  logic [XLEN-1:0] o_IC_Instr;

  logic            i_DM_MemRead;
  logic            i_DM_Wen;
  logic [XLEN-1:0] i_DM_Addr;
  logic [XLEN-1:0] i_DM_Wd;
  logic [2:0]      i_DM_f3;
`ifdef ARB_ATOMIC_LOCK_EN
  logic            i_DM_atomic;
`endif
  logic            o_DM_data_ready;
  logic [XLEN-1:0] o_DM_ReadData;

  logic            o_MEM_req;
  logic            o_MEM_we;
  logic [XLEN-1:0] o_MEM_addr;
  logic [XLEN-1:0] o_MEM_wdata;
  logic [2:0]      o_MEM_f3;
  logic            i_MEM_ready;
  logic [XLEN-1:0] i_MEM_rdata;

  // The arbiter masters the shared memory bus and serves both HART ports.
  modport master (
    input  i_IC_DataReq, i_IC_Addr,
    output o_IC_MemReady, o_IC_Instr,
    input  i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
`ifdef ARB_ATOMIC_LOCK_EN
    input  i_DM_atomic,
`endif
    output o_DM_data_ready, o_DM_ReadData,
    output o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_f3,
    input  i_MEM_ready, i_MEM_rdata
  );

  modport slave (
    output i_IC_DataReq, i_IC_Addr,
    input  o_IC_MemReady, o_IC_Instr,
    output i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_Wd, i_DM_f3,
`ifdef ARB_ATOMIC_LOCK_EN
    output i_DM_atomic,
`endif
    input  o_DM_data_ready, o_DM_ReadData,
    input  o_MEM_req, o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_f3,
    output i_MEM_ready, i_MEM_rdata
  );
endinterface

// File: rtl/hart_mem_arbiter.sv
// rtl/hart_mem_arbiter.sv - Round-robin arbiter sharing one memory bus between HART IC and DM ports.
// Optional atomic DM lock enabled by defining ARB_ATOMIC_LOCK_EN.
module hart_mem_arbiter #(
  parameter int XLEN = 32
`ifdef ARB_ATOMIC_LOCK_EN
  , parameter int LOCK_TIMEOUT = 16
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  hart_mem_arbiter_if.master   bus
);
  typedef enum logic [1:0] {IDLE, IC_BUSY, DM_BUSY} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;          // 0: IC wins a tie, 1: DM wins a tie
  logic [1:0]      cool_q, cool_d;      // bit0 IC, bit1 DM
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;

  logic ic_req, dm_req, ic_elig, dm_elig, grant_ic, grant_dm, lock_eff;

  assign ic_req   = bus.i_IC_DataReq;
  assign dm_req   = bus.i_DM_MemRead | bus.i_DM_Wen;
  assign ic_elig  = ic_req & ~cool_q[0] & ~lock_eff;
  assign dm_elig  = dm_req & ~cool_q[1];
  assign grant_ic = ic_elig & (~dm_elig | ~rr_q);
  assign grant_dm = dm_elig & (~ic_elig | rr_q);

`ifdef ARB_ATOMIC_LOCK_EN
  logic       lock_q, lock_d;
  logic [4:0] cnt_q, cnt_d;

  // Lock lapses in the same cycle the DM side drops atomic or the idle budget runs out.
  assign lock_eff = lock_q & bus.i_DM_atomic & (cnt_q < 5'(LOCK_TIMEOUT));

  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE) begin
      if (grant_dm) begin
        lock_d = bus.i_DM_atomic;
        cnt_d  = '0;
      end else begin
        lock_d = lock_eff;
        if (!lock_eff || dm_req) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign lock_eff = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cool_d  = cool_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        cool_d = 2'b00;
        if (grant_ic) begin
          state_d = IC_BUSY;
          we_d    = 1'b0;
          addr_d  = bus.i_IC_Addr;
          wdata_d = '0;
          f3_d    = 3'b010;
        end else if (grant_dm) begin
          state_d = DM_BUSY;
          we_d    = bus.i_DM_Wen;
          addr_d  = bus.i_DM_Addr;
          wdata_d = bus.i_DM_Wd;
          f3_d    = bus.i_DM_f3;
        end
      end
      IC_BUSY: begin
        if (bus.i_MEM_ready) begin
          state_d = IDLE;
          rr_d    = 1'b1;
          cool_d  = 2'b01;
        end
      end
      DM_BUSY: begin
        if (bus.i_MEM_ready) begin
          state_d = IDLE;
          rr_d    = 1'b0;
          cool_d  = 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cool_q  <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cool_q  <= cool_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end

  assign bus.o_MEM_req       = (state_q != IDLE);
  assign bus.o_MEM_we        = we_q;
  assign bus.o_MEM_addr      = addr_q;
  assign bus.o_MEM_wdata     = wdata_q;
  assign bus.o_MEM_f3        = f3_q;
  assign bus.o_IC_MemReady   = (state_q == IC_BUSY) & bus.i_MEM_ready;
  assign bus.o_DM_data_ready = (state_q == DM_BUSY) & bus.i_MEM_ready;
  assign bus.o_IC_Instr      = bus.i_MEM_rdata;
  assign bus.o_DM_ReadData   = bus.i_MEM_rdata;
endmodule
